// File: rtl/mux_arb.sv
// mux_arb: registered NCH:1 channel multiplexer with direct-select (mode=0) and round-robin (mode=1) arbitration.
// Optional macro MUX_ARB_LOCK_EN adds in_last and keeps round-robin grants on one channel for a whole packet.
module mux_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NCH-1:0]       in_last,
`endif
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    if (WIDTH < 1 || WIDTH > 64 || !(NCH == 2 || NCH == 4 || NCH == 8 || NCH == 16)) begin : g_bad_param
        $error("mux_arb: unsupported WIDTH/NCH combination");
    end

    logic [WIDTH-1:0] ch_data [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
`ifdef MUX_ARB_LOCK_EN
    logic             lock_q, lock_d;
`endif

    logic             advance;
    logic [SELW-1:0]  probe;
    logic [SELW-1:0]  rr_idx;
    logic             rr_hit;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_hit;
    logic [NCH-1:0]   grant;

    assign advance = !out_valid_q || out_ready;

    // Rotating priority: ptr+1 first, wrapping through the power-of-two index space back to ptr itself.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        probe  = '0;
        for (int k = 1; k <= NCH; k++) begin
            probe = ptr_q + SELW'(k);
            if (!rr_hit && in_valid[probe]) begin
                rr_hit = 1'b1;
                rr_idx = probe;
            end
        end
    end

    always_comb begin
        gnt_idx = sel;
        gnt_hit = 1'b0;
        if (!mode) begin
            gnt_idx = sel;
            gnt_hit = in_valid[sel];
        end
`ifdef MUX_ARB_LOCK_EN
        else if (lock_q) begin
            // Mid-packet: only the channel that owns the packet may be granted.
            gnt_idx = ptr_q;
            gnt_hit = in_valid[ptr_q];
        end
`endif
        else begin
            gnt_idx = rr_idx;
            gnt_hit = rr_hit;
        end
    end

    always_comb begin
        grant          = '0;
        grant[gnt_idx] = gnt_hit;
    end

    // Reset gates the strobes so no upstream handshake can complete while rst_n is low.
    assign in_ready = (advance && rst_n) ? grant : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (advance) begin
            out_valid_d = gnt_hit;
            if (gnt_hit) begin
                out_data_d = ch_data[gnt_idx];
                out_ch_d   = gnt_idx;
                if (mode) begin
                    ptr_d = gnt_idx;
                end
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (advance && gnt_hit && mode) begin
            lock_d = !in_last[gnt_idx];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(NCH - 1);
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: behavioural reference model checked every cycle plus directed literal checks.
module tb_mux_arb;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [SW-1:0]  out_ch;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]   in_last = '1;
`endif

    int errors = 0;
    int checks = 0;

    mux_arb #(.WIDTH(W), .NCH(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
`ifdef MUX_ARB_LOCK_EN
        .in_last  (in_last),
`endif
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h1111;
    endfunction

    task automatic set_ch(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < N; i++) set_ch(i, pat(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: output register contents, rotation pointer and packet lock.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [SW-1:0] m_ch   = '0;
    int           m_ptr   = N - 1;
    bit           m_lock  = 1'b0;

    function automatic int pick();
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        if (m_lock) return in_valid[m_ptr] ? m_ptr : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = pick();
        if (rst_n && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = '0;
            m_ptr   = N - 1;
            m_lock  = 1'b0;
        end else begin
            int g;
            g = pick();
            if (!m_valid || out_ready) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = in_data[g*W +: W];
                    m_ch    = SW'(g);
                    if (mode) begin
                        m_ptr = g;
`ifdef MUX_ARB_LOCK_EN
                        m_lock = !in_last[g];
`endif
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_out_valid", out_valid, m_valid);
        chk("mdl_out_data", out_data, m_data);
        chk("mdl_out_ch", out_ch, m_ch);
        chk("mdl_in_ready", in_ready, exp_ready());
    end

    logic [SW-1:0] rr [8];
    logic [SW-1:0] lk [4];
    int exp40 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1; in_valid = '1;
        load_pattern();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);

        // Direct select right after reset release
        tick(); rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 32'hA5A5A5A5);
        @(negedge clk); chk("r39_in_ready", in_ready, 4'b0100); chk("r39_pre_valid", out_valid, 0);
        tick(); in_valid = '0;
        @(negedge clk);
        chk("r39_data", out_data, 32'hA5A5A5A5); chk("r39_ch", out_ch, 2); chk("r39_valid", out_valid, 1);

        // Round robin with all channels valid
        tick(); mode = 1'b1; in_valid = 4'b1111; load_pattern();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) in_valid = 4'b0010;
            @(negedge clk); rr[i] = out_ch; chk("r40_valid", out_valid, 1);
        end
        for (int i = 0; i < 8; i++) chk("r40_seq", rr[i], exp40[i]);

        // Backpressure holds ch1 beat
        tick(); out_ready = 1'b0; in_valid = 4'b1111;
        @(negedge clk); chk("r41_ch", out_ch, 1); chk("r41_valid", out_valid, 1); chk("r41_data", out_data, pat(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("r41_hold_ch", out_ch, 1); chk("r41_hold_data", out_data, pat(1));
            chk("r41_hold_valid", out_valid, 1); chk("r41_hold_ready", in_ready, 4'b0000);
        end
        tick(); out_ready = 1'b1;
        @(negedge clk); chk("r41_grant", in_ready, 4'b0100);
        tick(); out_ready = 1'b0;
        @(negedge clk); chk("r41_next_ch", out_ch, 2); chk("r41_next_data", out_data, pat(2));
        tick();
        @(negedge clk); chk("r41_one_xfer", out_ch, 2); chk("r41_stall_ready", in_ready, 4'b0000);

        // Sparse arbitration from ptr=1 wraps from ch3 to ch0
        tick(); out_ready = 1'b1; in_valid = 4'b0010;
        @(negedge clk); chk("r42_setup", in_ready, 4'b0010);
        tick(); in_valid = 4'b1001;
        @(negedge clk); chk("r42_first_gnt", in_ready, 4'b1000);
        tick();
        @(negedge clk); chk("r42_ch3", out_ch, 3); chk("r42_wrap_gnt", in_ready, 4'b0001);
        tick();
        @(negedge clk); chk("r42_ch0", out_ch, 0);

        // Direct select with invalid channel empties the output; ptr untouched in mode 0
        tick(); mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        @(negedge clk); chk("r24_no_gnt", in_ready, 0); chk("r24_ch", out_ch, 3);
        tick(); sel = 2'd1;
        @(negedge clk);
        chk("r24_idle_valid", out_valid, 0); chk("r24_keep_ch", out_ch, 3);
        chk("r24_keep_data", out_data, pat(3)); chk("r16_sel_gnt", in_ready, 4'b0010);
        tick(); mode = 1'b1; in_valid = 4'b1111;
        @(negedge clk); chk("r16_ch", out_ch, 1); chk("r23_ptr_kept", in_ready, 4'b0001);

        // Reset mid-operation
        tick(); out_ready = 1'b0;
        @(negedge clk); chk("r43_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r43_valid", out_valid, 0); chk("r43_data", out_data, 0);
        chk("r43_ch", out_ch, 0); chk("r43_ready", in_ready, 0);
        tick(); rst_n = 1'b1; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        @(negedge clk); chk("r43_gnt", in_ready, 4'b0001);
        tick(); in_valid = '0;
        @(negedge clk); chk("r43_ch0", out_ch, 0); chk("r43_valid_after", out_valid, 1);

`ifdef MUX_ARB_LOCK_EN
        // Packet lock: ch1 sends three beats while ch2 waits
        tick(); in_valid = 4'b0110; in_last = 4'b0000;
        @(negedge clk); chk("r44_first_gnt", in_ready, 4'b0010);
        tick();
        @(negedge clk); lk[0] = out_ch;
        tick(); in_last = 4'b0010;
        @(negedge clk); lk[1] = out_ch;
        tick();
        @(negedge clk); lk[2] = out_ch;
        tick();
        @(negedge clk); lk[3] = out_ch;
        chk("r44_b0", lk[0], 1); chk("r44_b1", lk[1], 1); chk("r44_b2", lk[2], 1); chk("r44_after", lk[3], 2);
`endif

        // Directed sweep of mode/sel/valid/ready combinations against the model
        for (int i = 0; i < 64; i++) begin
            tick();
            mode      = ((i / 8) % 2) == 1;
            sel       = SW'(i % 4);
            in_valid  = N'((i * 7 + 3) % 16);
            out_ready = (i % 3) != 2;
            for (int c = 0; c < N; c++) set_ch(c, 32'(i * 16 + c));
`ifdef MUX_ARB_LOCK_EN
            in_last = ((i % 2) == 1) ? 4'b1111 : 4'b0000;
`endif
        end
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data bits per channel; legal range 1..64.
REQ-002 Parameter NCH, default 4, number of input channels; legal values 2, 4, 8, 16.
REQ-003 Derived SELW = log2(NCH), the width of the channel index.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_data, input, NCH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, NCH, per-channel valid.
REQ-008 Port in_ready, output, NCH, per-channel accept strobe (combinational).
REQ-009 Port mode, input, 1, 0 = direct select, 1 = round-robin arbitration.
REQ-010 Port sel, input, SELW, the channel index used when mode=0.
REQ-011 Port out_data, output, WIDTH, registered selected data.
REQ-012 Port out_valid, output, 1, out_data holds an unconsumed beat.
REQ-013 Port out_ready, input, 1, the downstream accepts a beat when out_valid and out_ready are both 1.
REQ-014 Port out_ch, output, SELW, the source channel index of the beat in out_data.

Function
REQ-015 advance = !out_valid || out_ready; the output register loads only when advance=1.
REQ-016 When mode=0, the candidate is channel sel, and it is granted iff in_valid[sel]=1.
REQ-017 When mode=1, the candidate is the first channel with in_valid=1, searching upward from ptr+1 modulo NCH.
REQ-018 In mode=1, ptr wraps from NCH-1 to 0.
REQ-019 in_ready[i] = advance && grant[i], where at most one grant bit is set per cycle.
REQ-020 A beat transfers from channel i when in_valid[i] and in_ready[i] are both 1.
REQ-021 On a transfer, the next cycle shows out_data = channel i data, out_ch = i and out_valid = 1 (latency 1 cycle).
REQ-022 On a transfer in mode=1, ptr is set to i.
REQ-023 In mode=0, ptr is never updated.
REQ-024 If advance=1 and no channel is granted, out_valid becomes 0 next cycle; out_data and out_ch keep their values.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid remain stable and all in_ready are 0.
REQ-026 A full output with out_ready=1 accepts a new beat in the same cycle it is consumed, sustaining 1 beat/clock.
REQ-027 Changes to mode or sel take effect at the next arbitration and never alter a held output beat.
REQ-028 With all channels valid in mode=1, grants rotate 0,1,..,NCH-1,0 with no channel granted twice before every other channel is granted once.

Reset
REQ-029 rst_n=0 forces out_valid=0, out_data=0 and out_ch=0 asynchronously.
REQ-030 rst_n=0 forces ptr=NCH-1, so channel 0 has first priority.
REQ-031 While rst_n=0, all in_ready shall be 0.
REQ-032 Reset asserted mid-transfer discards the held beat without a handshake.
REQ-033 The first transfer occurs no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro MUX_ARB_LOCK_EN, when defined, adds port in_last, input, NCH, which marks the final beat of a packet.
REQ-035 With MUX_ARB_LOCK_EN defined, mode=1 grants stay locked to the current channel after a beat with in_last=0 transfers, until a beat with in_last=1 transfers from it.
REQ-036 With MUX_ARB_LOCK_EN defined, the lock clears on reset.
REQ-037 With MUX_ARB_LOCK_EN defined, mode=0 ignores in_last.
REQ-038 Without MUX_ARB_LOCK_EN, port in_last does not exist and arbitration is re-evaluated every beat.

Verification
REQ-039 Reset check: after reset release, mode=0, sel=2, in_valid=4'b0100, ch2 data=0xA5A5A5A5, out_ready=1 -> next cycle out_data=0xA5A5A5A5, out_ch=2, out_valid=1.
REQ-040 Round-robin check: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
REQ-041 Backpressure check: out_valid=1 with out_ch=1, then out_ready=0 for 5 cycles -> out_data and out_ch unchanged, in_ready=4'b0000, then ready for 1 cycle -> exactly one transfer.
REQ-042 Sparse arbitration check: mode=1, ptr=1, in_valid=4'b1001 -> ch3 granted first, then ch0 (wrap-around).
REQ-043 Reset mid-operation check: assert rst_n=0 while out_valid=1 -> out_valid=0 immediately; after release, ch0 wins in mode=1 with in_valid=4'b1111.
REQ-044 Lock check (MUX_ARB_LOCK_EN defined): mode=1, ch1 sends 3 beats with in_last=0,0,1 while ch2 is valid -> out_ch=1,1,1 then 2.
